// File: rtl/pulse_buffer_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// pulse_buffer_write_ctrl_if
//
// Purpose : bundles the control, requester handshake, BRAM write port and
//           status signals of pulse_buffer_write_ctrl into one interface.
//
// Signals :
//   run          level, 1 = accept pulses
//   start        single-cycle pulse, clears the write count and enters RUN
//   req_valid    [NREQ]      per-requester word valid
//   req_data     [NREQ*DW]   requester i occupies bits [i*DW +: DW]
//   req_ready    [NREQ]      per-requester accept, at most one bit high
//   bram_we      BRAM write enable
//   bram_addr    [AW]        BRAM write address
//   bram_din     [DW]        BRAM write data
//   pulses_addr  [32]        running count of words written
//   overflow     sticky, count wrapped past 2^32-1
//
// Modports:
//   master : the side that drives run/start/requests (channel side / bench)
//   slave  : the write controller itself
// ---------------------------------------------------------------------------
interface pulse_buffer_write_ctrl_if #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int AW   = 10
);
    logic                 run;
    logic                 start;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 bram_we;
    logic [AW-1:0]        bram_addr;
    logic [DW-1:0]        bram_din;
    logic [31:0]          pulses_addr;
    logic                 overflow;

    modport master (
        output run,
        output start,
        output req_valid,
        output req_data,
        input  req_ready,
        input  bram_we,
        input  bram_addr,
        input  bram_din,
        input  pulses_addr,
        input  overflow
    );

    modport slave (
        input  run,
        input  start,
        input  req_valid,
        input  req_data,
        output req_ready,
        output bram_we,
        output bram_addr,
        output bram_din,
        output pulses_addr,
        output overflow
    );
endinterface

// File: rtl/pulse_buffer_write_ctrl.sv
// ---------------------------------------------------------------------------
// pulse_buffer_write_ctrl
//
// Purpose : round-robin arbiter and write sequencer for the pulse packet
//           buffer. Pulse words from NREQ requesters are written one per
//           cycle into a circular dual-port BRAM of 2^AW words. A 32-bit
//           running write count is published as pulses_addr so software
//           knows how far the buffer holds valid data. Single clock domain
//           (user_clk).
//
// Ports   :
//   user_clk    sole clock, rising edge
//   user_rst_n  asynchronous active-low reset
//   bus         pulse_buffer_write_ctrl_if.slave (run, start, req_valid,
//               req_data, req_ready, bram_we, bram_addr, bram_din,
//               pulses_addr, overflow)
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   DW    pulse word width
//   AW    BRAM address width
//
// Build option:
//   PULSES_ADDR_GRAY_EN  when defined, pulses_addr carries the Gray code of
//                        the write count so a register in another clock
//                        domain sees at most one bit change per update.
//                        When undefined, pulses_addr is plain binary.
//                        bram_addr is binary in both builds.
//
// Timing  : accept in cycle T, BRAM write in T+1, count/pulses_addr update
//           visible in T+2. pulses_addr therefore never names a word that
//           has not been written yet.
// ---------------------------------------------------------------------------
module pulse_buffer_write_ctrl #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int AW   = 10
) (
    input  logic                          user_clk,
    input  logic                          user_rst_n,
    pulse_buffer_write_ctrl_if.slave      bus
);

    // Pointer width, and one extra bit for the modulo search arithmetic.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PE = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef PULSES_ADDR_GRAY_EN
    // Binary to reflected Gray code.
    function automatic logic [31:0] to_gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]     state_q,       state_d;
    logic [PW-1:0]  rr_ptr_q,      rr_ptr_d;
    logic [31:0]    count_q,       count_d;
    // Set for a write in flight whose completion must bump the count.
    logic           wr_cnt_q,      wr_cnt_d;
    logic           bram_we_q,     bram_we_d;
    logic [AW-1:0]  bram_addr_q,   bram_addr_d;
    logic [DW-1:0]  bram_din_q,    bram_din_d;
    logic [31:0]    pulses_addr_q, pulses_addr_d;
    logic           overflow_q,    overflow_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [NREQ-1:0] grant_s;
    logic [PW-1:0]   grant_idx_s;
    logic            accept_s;
    logic [PE-1:0]   idx_ext_s;
    logic [DW-1:0]   sel_data_s;
    logic [31:0]     wr_ptr_s;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        accept_s    = 1'b0;
        idx_ext_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_ext_s = {1'b0, rr_ptr_q} + PE'(k);
            if (idx_ext_s >= PE'(NREQ)) begin
                idx_ext_s = idx_ext_s - PE'(NREQ);
            end else begin
                idx_ext_s = idx_ext_s;
            end
            if ((state_q == ST_RUN) && !accept_s &&
                bus.req_valid[idx_ext_s[PW-1:0]]) begin
                accept_s                       = 1'b1;
                grant_idx_s                    = idx_ext_s[PW-1:0];
                grant_s[idx_ext_s[PW-1:0]]     = 1'b1;
            end else begin
                accept_s = accept_s;
            end
        end
    end

    // Data mux for the granted requester (grant is one-hot or zero).
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_data_s = bus.req_data[i*DW +: DW];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state logic: FSM, pointer, write pipeline and counters.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        count_d       = count_q;
        wr_cnt_d      = 1'b0;
        bram_we_d     = 1'b0;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        overflow_d    = overflow_q;
        pulses_addr_d = pulses_addr_q;

        // A write still in flight has not bumped count yet, so a back-to-back
        // accept must target the slot after it.
        wr_ptr_s = count_q + {31'd0, wr_cnt_q};

        case (state_q)
            ST_IDLE: begin
                if (bus.start || bus.run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            bram_we_d   = 1'b1;
            bram_addr_d = wr_ptr_s[AW-1:0];
            bram_din_d  = sel_data_s;
            // A word accepted together with start lands at the pre-start
            // address but must not count against the freshly cleared total.
            wr_cnt_d    = !bus.start;
            if (grant_idx_s == PW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + PW'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // start wins over the increment of any write completing this cycle.
        if (bus.start) begin
            count_d    = 32'd0;
            overflow_d = 1'b0;
        end else if (wr_cnt_q) begin
            count_d = count_q + 32'd1;
            if (count_q == 32'hFFFF_FFFF) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            count_d = count_q;
        end

`ifdef PULSES_ADDR_GRAY_EN
        pulses_addr_d = to_gray(count_d);
`else
        pulses_addr_d = count_d;
`endif
    end

    // State and output registers with asynchronous reset; an in-flight write
    // is dropped because bram_we_q clears immediately.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            count_q       <= 32'd0;
            wr_cnt_q      <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            pulses_addr_q <= 32'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            count_q       <= count_d;
            wr_cnt_q      <= wr_cnt_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            pulses_addr_q <= pulses_addr_d;
            overflow_q    <= overflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. req_ready is combinational so an accept completes in the same
    // cycle the request is seen; it is zero outside RUN.
    // -----------------------------------------------------------------------
    assign bus.req_ready   = grant_s;
    assign bus.bram_we     = bram_we_q;
    assign bus.bram_addr   = bram_addr_q;
    assign bus.bram_din    = bram_din_q;
    assign bus.pulses_addr = pulses_addr_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_pulse_buffer_write_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pulse_buffer_write_ctrl. Stimulus pushes the expected BRAM
// writes into a queue; a monitor pops and compares on every bram_we cycle.
// Directed checks cover reset, grants, pulses_addr timing and run/start.
// ---------------------------------------------------------------------------
module tb_pulse_buffer_write_ctrl;
    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int AW   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pulse_buffer_write_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    pulse_buffer_write_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;
    logic [31:0] wn [NREQ];

    // Expected pulses_addr encoding of a word count.
    function automatic logic [31:0] exp_pa(input logic [31:0] n);
`ifdef PULSES_ADDR_GRAY_EN
        return n ^ (n >> 1);
`else
        return n;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d);
        wr_t t;
        t.addr = exp_cnt[AW-1:0];
        t.data = d;
        exp_q.push_back(t);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic set_data(input int i, input logic [63:0] d);
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"},    64'(bus.req_ready),   64'd0);
        chk({tag, "_we"},       64'(bus.bram_we),     64'd0);
        chk({tag, "_addr"},     64'(bus.bram_addr),   64'd0);
        chk({tag, "_din"},      bus.bram_din,         64'd0);
        chk({tag, "_pa"},       64'(bus.pulses_addr), 64'd0);
        chk({tag, "_overflow"}, 64'(bus.overflow),    64'd0);
    endtask

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && (bus.bram_we !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         bus.bram_addr, bus.bram_din);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.bram_addr), 64'(mon_e.addr));
                chk("wr_data", bus.bram_din, mon_e.data);
            end
        end
    end

    initial begin
        bus.run       = 1'b0;
        bus.start     = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // --- single requester 2, five words 0x10..0x14 ---
        bus.run   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt   = 32'd0;
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 4'b0100;
            set_data(2, 64'h10 + 64'(k));
            push(64'h10 + 64'(k));
            @(negedge clk);
            chk("t1_ready", 64'(bus.req_ready), 64'b0100);
            tick();
        end
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_pa_lag", 64'(bus.pulses_addr), 64'(exp_pa(32'd4)));
        tick();
        @(negedge clk);
        chk("t1_pa_final", 64'(bus.pulses_addr), 64'(exp_pa(32'd5)));
        tick();

        // --- move rr_ptr to 0 via requester 3, then restart the count ---
        bus.req_valid = 4'b1000;
        set_data(3, 64'hAA);
        push(64'hAA);
        @(negedge clk);
        chk("t2_pre_ready", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt   = 32'd0;
        @(negedge clk);
        chk("t2_pa_cleared", 64'(bus.pulses_addr), 64'(exp_pa(32'd0)));
        tick();

        // --- all four requesters valid for 8 cycles: grants 0,1,2,3,0,1,2,3 ---
        for (int i = 0; i < NREQ; i++) begin
            wn[i] = 32'd0;
            set_data(i, {32'(i), 32'd0});
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push({32'(k % 4), wn[k % 4]});
            @(negedge clk);
            chk("t2_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            wn[k % 4] = wn[k % 4] + 32'd1;
            set_data(k % 4, {32'(k % 4), wn[k % 4]});
        end
        bus.req_valid = '0;
        repeat (3) tick();
        chk("t2_pa", 64'(bus.pulses_addr), 64'(exp_pa(32'd8)));

        // --- buffer wrap: 1025 words, addresses run 0..1023 then 0 ---
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt   = 32'd0;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 1025; k++) begin
            set_data(0, 64'h3000_0000 + 64'(k));
            push(64'h3000_0000 + 64'(k));
            tick();
        end
        bus.req_valid = '0;
        repeat (3) tick();
        chk("t3_pa", 64'(bus.pulses_addr), 64'(exp_pa(32'd1025)));
        chk("t3_overflow", 64'(bus.overflow), 64'd0);

        // --- run dropped in the same cycle as an accept ---
        bus.req_valid = 4'b0010;
        set_data(1, 64'hBEEF);
        push(64'hBEEF);
        bus.run = 1'b0;
        @(negedge clk);
        chk("t4_ready", 64'(bus.req_ready), 64'b0010);
        tick();
        @(negedge clk);
        chk("t4_ready_off", 64'(bus.req_ready), 64'd0);
        tick();
        bus.req_valid = '0;
        repeat (2) tick();
        chk("t4_pa", 64'(bus.pulses_addr), 64'(exp_pa(32'd1026)));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt   = 32'd0;
        tick();
        chk("t4_pa_start", 64'(bus.pulses_addr), 64'(exp_pa(32'd0)));

        // --- four words after start: pulses_addr steps with two-cycle lag ---
        bus.run   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt   = 32'd0;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_data(0, 64'h5000 + 64'(k));
            push(64'h5000 + 64'(k));
            @(negedge clk);
            chk("t6_pa_step", 64'(bus.pulses_addr), 64'(exp_pa((k >= 1) ? 32'(k - 1) : 32'd0)));
            tick();
        end
        bus.req_valid = '0;
        @(negedge clk);
        chk("t6_pa_step3", 64'(bus.pulses_addr), 64'(exp_pa(32'd3)));
        tick();
        @(negedge clk);
        chk("t6_pa_step4", 64'(bus.pulses_addr), 64'(exp_pa(32'd4)));
        tick();

        // --- reset one cycle after an accept: write dropped, outputs zero ---
        bus.req_valid = 4'b0001;
        set_data(0, 64'hDEAD);
        @(negedge clk);
        chk("t5_ready", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        bus.req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("t5_async");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t5_we_after", 64'(bus.bram_we), 64'd0);
        chk("t5_pa_after", 64'(bus.pulses_addr), 64'd0);

        repeat (2) tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_buffer_write_ctrl.md
Name: pulse_buffer_write_ctrl

Overview:
- Round-robin arbiter and write sequencer for the pulse packet buffer.
- Collects pulse words from NREQ channel-side requesters and writes them one per cycle into a dual-port pulse BRAM (circular, 2^AW words).
- Publishes a 32-bit running write count as pulses_addr, which feeds the simulink2ppc pulses_addr software register so the PPC knows how far the buffer is valid.
- Runs entirely in the user_clk (DSP) domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 64, pulse word width in bits.
- AW, 10, BRAM address width; buffer depth is 2^AW words.

Ports:
- user_clk  in  1  sole clock; all logic rising-edge.
- user_rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = accept pulses, 0 = stop.
- start  in  1  single-cycle pulse; clears the write count and enters RUN.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DW  requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  AW  BRAM write address.
- bram_din  out  DW  BRAM write data.
- pulses_addr  out  32  running count of words written, to the register.
- overflow  out  1  sticky; set on count wrap past 2^32-1.

Behaviour:
- Reset (user_rst_n=0, async) values: state=IDLE, req_ready=0, bram_we=0, bram_addr=0, bram_din=0, pulses_addr=0, overflow=0, internal count=0, rr_ptr=0.
- IDLE state:
  - req_ready=0.
  - start=1 -> count<=0, pulses_addr<=0, overflow<=0, go to RUN.
  - run=1 without start -> go to RUN and keep the current count (resume).
- RUN state:
  - run=0 -> go to IDLE next cycle. Any word accepted in the final RUN cycle still completes its write and count update.
  - start=1 in RUN -> count<=0, pulses_addr<=0, overflow<=0. A write already in flight still lands at its old address, but the count reset wins over that write's increment.
- Arbitration (combinational, RUN only):
  - Search from rr_ptr upward, modulo NREQ; the first i with req_valid[i] gets req_ready[i]=1.
  - Accept = req_valid[i] & req_ready[i]. On accept, rr_ptr<=(i+1) mod NREQ.
  - With no valid request, rr_ptr holds.
- Write pipeline:
  - Accept in cycle T.
  - Cycle T+1: bram_we=1, bram_addr=count[AW-1:0], bram_din=req_data slice i.
  - Cycle T+2: count<=count+1 and pulses_addr<=count+1.
  - pulses_addr therefore never names a word not yet written.
  - bram_we=0 in any cycle without a preceding accept.
- Throughput: one word per cycle sustained; back-to-back accepts from different requesters are allowed.
- Counter widths:
  - count is 32 bits; bram_addr is the low AW bits, so buffer wrap (2^AW-1 -> 0) is implicit and the PPC derives the lap from the upper bits.
  - count wrap 0xFFFFFFFF -> 0 sets overflow=1, held until start or reset.
- Simultaneous start and accept in the same cycle: the accept is honoured and writes at the pre-start address, then count=0.
- Mid-operation reset: all outputs return immediately to reset values; the in-flight write is dropped (bram_we forced 0).
- req_data changes while not accepted are ignored. A requester must hold valid/data until it sees ready.

Optional Feature:
- Macro: PULSES_ADDR_GRAY_EN.
- Defined: pulses_addr is registered as the Gray code of the count (count ^ (count>>1)), with the same T+2 timing, so the OPB-side register can sample it across clock domains with at most one bit changing per update. Reset value is 0.
- Undefined: pulses_addr is plain binary.
- bram_addr is binary in both builds.

Test Plan:
- Reset then start, single requester: req_valid[2]=1 for 5 cycles, data 0x10..0x14 -> bram_we on 5 consecutive cycles at addr 0..4 with data 0x10..0x14; pulses_addr steps 1..5, final value 5.
- All four requesters valid continuously for 8 cycles from rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3; one-hot req_ready each cycle; pulses_addr=8.
- Buffer wrap, AW=10: preload count to 1023 and write 2 words -> bram_addr 1023 then 0; pulses_addr=1025; overflow stays 0.
- run deasserted in the same cycle as an accept -> that word is written and pulses_addr increments; req_ready=0 from the next cycle; a following start zeroes pulses_addr.
- user_rst_n pulsed low one cycle after an accept -> bram_we never asserts for that word; all outputs 0 immediately, asynchronously.
- With PULSES_ADDR_GRAY_EN, write 4 words -> pulses_addr sequence 1,3,2,6, and successive values differ by exactly one bit.
